// File: rtl/dcache_controller.sv
// Hit/miss sequencing for a direct-mapped, write-through, no-write-allocate data cache.
// Holds the valid/tag arrays, stalls the core on misses and stores, and drives word-serial refills.
module dcache_controller #(
  parameter int ADDR_W   = 12,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                stall,
  output logic                hit,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ready,
  output logic                cache_we,
  output logic [INDEX_W-1:0]  cache_index,
  output logic [OFFSET_W-1:0] cache_word,
  output logic                cache_src
);

  localparam int NLINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [NLINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [NLINES];
  logic                fill_done;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_word;
  logic                addr_lsb_unused;

  assign addr_tag        = cpu_addr[ADDR_W-1 -: TAG_W];
  assign addr_index      = cpu_addr[OFFSET_W+2 +: INDEX_W];
  assign addr_word       = cpu_addr[2 +: OFFSET_W];
  assign addr_lsb_unused = ^cpu_addr[1:0];

  assign hit       = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign fill_done = (state_q == REFILL) && mem_ready && (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Tag storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[addr_index] <= addr_tag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          state_d = WRITE;
        end else if (cpu_rd && !hit) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (cnt_q == '1) begin
            valid_d[addr_index] = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      WRITE: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    cache_we    = 1'b0;
    cache_index = addr_index;
    cache_word  = addr_word;
    cache_src   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = cpu_wr || (cpu_rd && !hit);
      end
      REFILL: begin
        stall      = 1'b1;
        mem_rd_req = 1'b1;
        mem_addr   = {addr_tag, addr_index, cnt_q, 2'b00};
        cache_word = cnt_q;
        cache_src  = 1'b1;
        cache_we   = mem_ready;
      end
      WRITE: begin
        // Stall release depends on mem_ready, but the request strobes do not.
        stall      = !mem_ready;
        mem_wr_req = 1'b1;
        mem_addr   = {cpu_addr[ADDR_W-1:2], 2'b00};
        cache_we   = mem_ready && hit;
      end
      default: ;
    endcase
  end

endmodule
